// File: rtl/sr_iter_if.sv
// Request/response bundle for the iterative right shifter: operand, amount and
// mode toward the shifter, result and status back to the requester.
interface sr_iter_if;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] result;
    logic        busy;
    logic        done;

    modport master (
        output start, data_in, shamt, arith,
        input  result, busy, done
    );

    modport slave (
        input  start, data_in, shamt, arith,
        output result, busy, done
    );
endinterface

// File: rtl/sr_iter.sv
// Multi-cycle 32-bit right shifter: five conditional stages (16, 8, 4, 2, 1),
// one per clock, then a one-cycle done pulse with the result held afterwards.
module sr_iter (
    input  logic      clock,
    input  logic      resetn,
    sr_iter_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] w_q, w_d;
    logic [4:0]  s_q, s_d;
    logic        f_q, f_d;
    logic [2:0]  k_q, k_d;

    logic [4:0]  stage_amt;
    logic [31:0] stage_out;

    // One stage shifts by 2^k; vacated upper bits take the fill bit captured at acceptance.
    always_comb begin
        stage_amt = 5'd1 << k_q;
        stage_out = (w_q >> stage_amt) | ({32{f_q}} & ~(32'hFFFF_FFFF >> stage_amt));
    end

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        w_d     = w_q;
        s_d     = s_q;
        f_d     = f_q;
        k_d     = k_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    w_d     = bus.data_in;
                    s_d     = bus.shamt;
                    f_d     = bus.arith & bus.data_in[31];
                    k_d     = 3'd4;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (s_q[k_q]) begin
                    w_d = stage_out;
                end
                // All five stages always run, even for a zero amount, so latency is fixed.
                if (k_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!resetn) begin
            state_q <= IDLE;
            w_q     <= '0;
            s_q     <= '0;
            f_q     <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            s_q     <= s_d;
            f_q     <= f_d;
            k_q     <= k_d;
        end
    end

    assign bus.result = w_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_sr_iter.sv
// Directed bench for sr_iter: hand-computed shifts, cycle-exact busy/done timing,
// ignored starts while busy, held-start retrigger and mid-operation reset.
module tb_sr_iter;

    logic clock;
    logic resetn;
    int   total;
    int   bad;

    sr_iter_if bus ();

    sr_iter dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_result);
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " done"}, {31'd0, bus.done}, 32'd0);
        check({tag, " result"}, bus.result, exp_result);
    endtask

    // Accepts a request in the current cycle N and checks cycles N+1..N+7.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sh,
                          input logic a, input logic [31:0] exp_result);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.shamt   = sh;
        bus.arith   = a;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("%s busy@N+%0d", tag, i), {31'd0, bus.busy}, 32'd1);
            check($sformatf("%s done@N+%0d", tag, i), {31'd0, bus.done}, (i == 6) ? 32'd1 : 32'd0);
            if (i < 6) tick();
        end
        check({tag, " result@done"}, bus.result, exp_result);
        tick();
        check_idle({tag, " @N+7"}, exp_result);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        resetn      = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = 32'h0;
        bus.shamt   = 5'd0;
        bus.arith   = 1'b0;

        // Reset for two cycles, then idle with start low.
        tick();
        check_idle("reset1", 32'h0);
        tick();
        check_idle("reset2", 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("idle%0d", i), 32'h0);
        end

        // Logical shift, result held until N+10.
        run_op("lsr8", 32'h80F0_1234, 5'd8, 1'b0, 32'h0080_F012);
        for (int i = 8; i <= 10; i++) begin
            tick();
            check_idle($sformatf("lsr8 hold@N+%0d", i), 32'h0080_F012);
        end

        run_op("asr31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        run_op("lsr31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        run_op("asr4pos", 32'h7FFF_FFFF, 5'd4, 1'b1, 32'h07FF_FFFF);
        run_op("sh0", 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
        run_op("asr5neg", 32'hF000_0A50, 5'd5, 1'b1, 32'hFF80_0052);
        run_op("lsr19", 32'hF000_0A50, 5'd19, 1'b0, 32'h0000_1E00);

        // Start pulses while busy are ignored; held start retriggers every 7 cycles.
        tick();
        bus.start   = 1'b1;
        bus.data_in = 32'h0000_FF00;
        bus.shamt   = 5'd4;
        bus.arith   = 1'b0;
        tick();                                   // N+1
        bus.start = 1'b0;
        tick();                                   // N+2
        tick();                                   // N+3
        bus.start   = 1'b1;
        bus.data_in = 32'hFFFF_FFFF;
        bus.shamt   = 5'd1;
        bus.arith   = 1'b1;
        tick();                                   // N+4
        bus.start = 1'b0;
        check("busy ign done@N+4", {31'd0, bus.done}, 32'd0);
        tick();                                   // N+5
        check("busy ign done@N+5", {31'd0, bus.done}, 32'd0);
        tick();                                   // N+6
        check("busy ign done@N+6", {31'd0, bus.done}, 32'd1);
        check("busy ign result", bus.result, 32'h0000_0FF0);
        bus.start = 1'b1;
        tick();                                   // N+7
        check_idle("busy ign @N+7", 32'h0000_0FF0);
        bus.data_in = 32'h0000_0100;
        bus.shamt   = 5'd8;
        bus.arith   = 1'b0;
        for (int i = 8; i <= 13; i++) begin
            tick();
            check($sformatf("held busy@N+%0d", i), {31'd0, bus.busy}, 32'd1);
            check($sformatf("held done@N+%0d", i), {31'd0, bus.done}, (i == 13) ? 32'd1 : 32'd0);
        end
        check("held result", bus.result, 32'h0000_0001);
        tick();                                   // N+14, start still high: retrigger
        check_idle("held @N+14", 32'h0000_0001);
        tick();                                   // N+15
        bus.start = 1'b0;
        check("retrig busy@N+15", {31'd0, bus.busy}, 32'd1);
        for (int i = 16; i <= 20; i++) begin
            tick();
            check($sformatf("retrig done@N+%0d", i), {31'd0, bus.done}, (i == 20) ? 32'd1 : 32'd0);
        end
        check("retrig result", bus.result, 32'h0000_0001);
        tick();

        // Reset in the middle of an operation aborts it without a done pulse.
        bus.start   = 1'b1;
        bus.data_in = 32'h1234_5678;
        bus.shamt   = 5'd12;
        bus.arith   = 1'b0;
        tick();                                   // N+1
        bus.start = 1'b0;
        tick();                                   // N+2
        tick();                                   // N+3
        check("abort busy@N+3", {31'd0, bus.busy}, 32'd1);
        resetn = 1'b0;
        tick();                                   // N+4
        resetn = 1'b1;
        check_idle("abort @N+4", 32'h0);
        tick();                                   // N+5
        check_idle("abort @N+5", 32'h0);
        run_op("after abort", 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
